// File: rtl/program_sequencer_if.sv
// Sequencer <-> ROM/datapath bundle: program control, ROM fetch port, decode outputs and ALU handshake.
interface program_sequencer_if;
    logic       run;
    logic [1:0] prog_sel;
    logic [1:0] rom_prog;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] ir;
    logic [7:0] pc;
    logic [1:0] dst_reg;
    logic [1:0] src_reg;
    logic [2:0] alu_op;
    logic       alu_start;
    logic       alu_done;
    logic       ld_a;
    logic       ld_b;
    logic       ld_l;
    logic       out_en;
    logic       busy;
    logic       halted;
    logic       error;

    modport master (
        input  run, prog_sel, rom_data, alu_done,
        output rom_prog, rom_addr, ir, pc, dst_reg, src_reg, alu_op,
               alu_start, ld_a, ld_b, ld_l, out_en, busy, halted, error
    );

    modport slave (
        output run, prog_sel, rom_data, alu_done,
        input  rom_prog, rom_addr, ir, pc, dst_reg, src_reg, alu_op,
               alu_start, ld_a, ld_b, ld_l, out_en, busy, halted, error
    );
endinterface

// File: rtl/program_sequencer.sv
// Fetch/decode/execute controller: 3 cycles per instruction, ALU ops add n>=1 wait cycles.
// ALU completion is awaited via alu_done with a bounded timeout that halts with a sticky error.
module program_sequencer #(
    parameter logic [7:0] ALU_TIMEOUT = 8'd16,
    parameter logic [7:0] START_ADDR  = 8'h00
) (
    input  logic                       clk,
    input  logic                       reset_n,
    program_sequencer_if.master        bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    logic [2:0] state;
    logic [7:0] pc_r;
    logic [7:0] ir_r;
    logic [7:0] wait_cnt;
    logic [1:0] prog_r;
    logic       err_r;
    logic [3:0] opcode;
    logic       exec;

    assign opcode = ir_r[7:4];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            pc_r     <= START_ADDR;
            ir_r     <= '0;
            prog_r   <= '0;
            err_r    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.run) begin
                        prog_r <= bus.prog_sel;
                        pc_r   <= START_ADDR;
                        err_r  <= 1'b0;
                        state  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    ir_r  <= bus.rom_data;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    state <= (opcode >= 4'hC) ? S_HALT : S_EXEC;
                end
                S_EXEC: begin
                    pc_r     <= pc_r + 8'd1;
                    wait_cnt <= 8'd1;
                    // opcode[3] clear means an ALU operation (0000-0111)
                    state    <= opcode[3] ? S_FETCH : S_WAIT;
                end
                S_WAIT: begin
                    if (bus.alu_done) begin
                        state <= S_FETCH;
                    end else if (wait_cnt == ALU_TIMEOUT) begin
                        err_r <= 1'b1;
                        state <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_HALT: begin
                    if (!bus.run) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes are pure decodes of EXEC, so they can never fire in any other state.
    assign exec          = (state == S_EXEC);
    assign bus.alu_start = exec && !opcode[3];
    assign bus.ld_l      = exec && (opcode == 4'h8);
    assign bus.ld_a      = exec && (opcode == 4'h9);
    assign bus.ld_b      = exec && (opcode == 4'hA);
    assign bus.out_en    = exec && (opcode == 4'hB);

    assign bus.alu_op    = opcode[3] ? 3'd0 : ir_r[6:4];
    assign bus.dst_reg   = ir_r[3:2];
    assign bus.src_reg   = ir_r[1:0];
    assign bus.ir        = ir_r;
    assign bus.pc        = pc_r;
    assign bus.rom_addr  = pc_r;
    assign bus.rom_prog  = prog_r;
    assign bus.error     = err_r;
    assign bus.halted    = (state == S_HALT);
    assign bus.busy      = (state == S_FETCH) || (state == S_DECODE) ||
                           (state == S_EXEC)  || (state == S_WAIT);
endmodule

// File: tb/tb_program_sequencer.sv
// Randomized bench for program_sequencer with an instruction-level timing model.
module tb_program_sequencer;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    program_sequencer_if bus();
    program_sequencer_if bus2();

    program_sequencer #(.ALU_TIMEOUT(TO[7:0]), .START_ADDR(8'h00)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );
    program_sequencer #(.ALU_TIMEOUT(TO[7:0]), .START_ADDR(8'hFE)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .bus(bus2)
    );

    logic [7:0] rom [4][256];
    assign bus.rom_data  = rom[bus.rom_prog][bus.rom_addr];
    assign bus2.rom_data = 8'hB0;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected per-cycle trace; cycle 1 is the first FETCH after run is sampled.
    int         dly [32];
    logic [4:0] exp_s   [512];
    logic [7:0] exp_pc  [512];
    logic [7:0] exp_ins [512];
    int         halt_t;
    int         obs_halt;
    logic [7:0] halt_pc;
    logic       to_flag;

    task automatic model(input logic [1:0] p);
        int t = 1;
        int k = 0;
        int e;
        logic [7:0] pc = 8'h00;
        logic [7:0] ins;
        logic [3:0] op;
        for (int i = 0; i < 512; i++) begin
            exp_s[i] = '0; exp_pc[i] = '0; exp_ins[i] = '0;
        end
        to_flag = 1'b0;
        halt_t  = 480;
        halt_pc = 8'h00;
        for (int g = 0; g < 256; g++) begin
            ins = rom[p][pc];
            op  = ins[7:4];
            if (op >= 4'hC) begin
                halt_t = t + 2; halt_pc = pc;
                break;
            end
            e = t + 2;
            if (e > 470) break;
            case (op)
                4'h8:    exp_s[e] = 5'b00010;
                4'h9:    exp_s[e] = 5'b01000;
                4'hA:    exp_s[e] = 5'b00100;
                4'hB:    exp_s[e] = 5'b00001;
                default: exp_s[e] = 5'b10000;
            endcase
            exp_pc[e]  = pc;
            exp_ins[e] = ins;
            pc = pc + 8'd1;
            if (op < 4'h8) begin
                if (dly[k] > TO) begin
                    to_flag = 1'b1; halt_t = e + 1 + TO; halt_pc = pc;
                    break;
                end
                t = e + 1 + dly[k];
                k++;
            end else begin
                t = e + 1;
            end
        end
    endtask

    // mode 0: quiet alu_done, steady run; 1: random noise and run toggling; 2: alu_done high outside waits
    task automatic run_prog(input logic [1:0] p, input int mode, input int hold);
        int t = 0;
        int k = 0;
        int start_c = -100;
        int done_at = -100;
        int quiet_to = -100;
        logic [4:0] s;
        model(p);
        obs_halt = -1;
        bus.prog_sel = p;
        bus.run = 1'b1;
        bus.alu_done = (mode == 2);
        while (t < halt_t + hold) begin
            @(posedge clk); #1;
            t++;
            s = {bus.alu_start, bus.ld_a, bus.ld_b, bus.ld_l, bus.out_en};
            if (bus.halted && obs_halt < 0) obs_halt = t;
            if (t == 1) begin
                chk("start_prog", 32'(bus.rom_prog), 32'(p));
                chk("start_addr", 32'(bus.rom_addr), 32'h0);
            end
            chk("strobes", 32'(s), 32'(exp_s[t]));
            chk("busy", 32'(bus.busy), 32'(t < halt_t));
            chk("halted", 32'(bus.halted), 32'(t >= halt_t));
            chk("error", 32'(bus.error), 32'(to_flag && t >= halt_t));
            if (exp_s[t] != 5'd0) chk("exec_pc", 32'(bus.pc), 32'(exp_pc[t]));
            if (exp_s[t][4]) begin
                chk("alu_op", 32'(bus.alu_op), 32'(exp_ins[t][6:4]));
                chk("dst_reg", 32'(bus.dst_reg), 32'(exp_ins[t][3:2]));
                chk("src_reg", 32'(bus.src_reg), 32'(exp_ins[t][1:0]));
            end
            if (t == halt_t) chk("halt_pc", 32'(bus.pc), 32'(halt_pc));
            if (bus.alu_start) begin
                start_c  = t;
                quiet_to = t + ((dly[k] <= TO) ? dly[k] - 1 : TO);
                done_at  = (dly[k] <= TO) ? t + dly[k] : -100;
                if (k < 31) k++;
            end
            if (t == done_at)                       bus.alu_done = 1'b1;
            else if (t > start_c && t <= quiet_to)  bus.alu_done = 1'b0;
            else if (mode == 1)                     bus.alu_done = 1'($urandom_range(0, 1));
            else                                    bus.alu_done = (mode == 2);
            if (t < halt_t) bus.run = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            else            bus.run = (t < halt_t + hold);
        end
        bus.run = 1'b0;
        bus.alu_done = 1'b0;
        @(posedge clk); #1;
        chk("idle_halted", 32'(bus.halted), 32'h0);
        chk("idle_busy", 32'(bus.busy), 32'h0);
        chk("err_sticky", 32'(bus.error), 32'(to_flag));
    endtask

    logic [1:0] rp;
    int         len;
    int         opv;
    logic [7:0] wpc;
    logic       seen;

    initial begin
        for (int p = 0; p < 4; p++)
            for (int a = 0; a < 256; a++) rom[p][a] = 8'hF0;
        bus.run = 1'b0;  bus.prog_sel = 2'd0;  bus.alu_done = 1'b0;
        bus2.run = 1'b0; bus2.prog_sel = 2'd0; bus2.alu_done = 1'b0;

        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", 32'(bus.pc), 32'h0);
        chk("rst_ir", 32'(bus.ir), 32'h0);
        chk("rst_prog", 32'(bus.rom_prog), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_halted", 32'(bus.halted), 32'h0);
        chk("rst_error", 32'(bus.error), 32'h0);
        chk("rst_strobes", 32'({bus.alu_start, bus.ld_a, bus.ld_b, bus.ld_l, bus.out_en}), 32'h0);
        chk("rst_wrap_pc", 32'(bus2.pc), 32'hFE);
        reset_n = 1'b1;

        // Program 2 directed sequence
        rom[2][0] = 8'h90; rom[2][1] = 8'hA4; rom[2][2] = 8'h21;
        rom[2][3] = 8'h40; rom[2][4] = 8'hB0; rom[2][5] = 8'hF0;
        dly[0] = 1; dly[1] = 1;
        run_prog(2'd2, 0, 2);
        chk("p2_total", 32'(obs_halt - 1), 32'd19);

        // ALU timeout, then restart clears error
        rom[0][0] = 8'h3D; rom[0][1] = 8'hF0;
        dly[0] = 40;
        run_prog(2'd0, 0, 3);
        chk("timeout_len", 32'(obs_halt - 4), 32'd16);

        // Early alu_done during EXEC must not shorten the wait
        rom[1][0] = 8'h52; rom[1][1] = 8'hF0;
        dly[0] = 3;
        run_prog(2'd1, 2, 1);

        for (int it = 0; it < 20; it++) begin
            rp  = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                opv = $urandom_range(0, 11);
                rom[rp][i] = {4'(opv), 4'($urandom)};
            end
            rom[rp][len] = {4'($urandom_range(12, 15)), 4'($urandom)};
            for (int i = 0; i < 32; i++)
                dly[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(17, 24) : $urandom_range(1, 6);
            run_prog(rp, 1, $urandom_range(0, 3));
        end

        // Reset in the middle of an ALU wait
        rom[3][0] = 8'h35; rom[3][1] = 8'hF0;
        bus.prog_sel = 2'd3; bus.run = 1'b1; bus.alu_done = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(posedge clk); #1;
            seen = bus.alu_start;
        end
        chk("mr_start", 32'(seen), 32'h1);
        bus.run = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mr_waiting", 32'(bus.busy), 32'h1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("mr_busy", 32'(bus.busy), 32'h0);
        chk("mr_halted", 32'(bus.halted), 32'h0);
        chk("mr_pc", 32'(bus.pc), 32'h0);
        chk("mr_ir", 32'(bus.ir), 32'h0);
        chk("mr_prog", 32'(bus.rom_prog), 32'h0);
        chk("mr_strobes", 32'({bus.alu_start, bus.ld_a, bus.ld_b, bus.ld_l, bus.out_en}), 32'h0);
        bus.alu_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("mr_late_done", 32'({bus.busy, bus.alu_start, bus.ld_a, bus.ld_b, bus.ld_l, bus.out_en}), 32'h0);
        end
        bus.alu_done = 1'b0;

        // PC wrap on the FE-start instance
        bus2.run = 1'b1;
        wpc = 8'hFE;
        for (int t = 1; t <= 13; t++) begin
            @(posedge clk); #1;
            chk("wrap_halted", 32'(bus2.halted), 32'h0);
            if (t % 3 == 0) begin
                chk("wrap_out_en", 32'(bus2.out_en), 32'h1);
                chk("wrap_pc", 32'(bus2.pc), 32'(wpc));
                wpc = wpc + 8'd1;
            end else begin
                chk("wrap_out_en", 32'(bus2.out_en), 32'h0);
            end
        end
        bus2.run = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
